// File: rtl/har_bnn1_rospine_classifier.sv
// Sequential binarized-NN classifier: one hidden neuron per clock, then one class score
// per clock with a running argmax; the winning class index is held on prediction.
module har_bnn1_rospine_classifier #(
  parameter int unsigned FEAT_CNT   = 12,
  parameter int unsigned HIDDEN_CNT = 40,
  parameter int unsigned FEAT_BITS  = 4,
  parameter int unsigned CLASS_CNT  = 6,
  parameter logic [HIDDEN_CNT*FEAT_CNT-1:0] W1 = '1,
  parameter logic [HIDDEN_CNT*$clog2(FEAT_CNT*(2**FEAT_BITS-1)+1)-1:0] T1 = {HIDDEN_CNT{8'd90}},
  parameter logic [CLASS_CNT*HIDDEN_CNT-1:0] W2 = '0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [FEAT_CNT*FEAT_BITS-1:0]  features,
  output logic [$clog2(CLASS_CNT)-1:0]   prediction
);

  localparam int unsigned S1 = $clog2(FEAT_CNT*(2**FEAT_BITS-1)+1);
  localparam int unsigned SW = $clog2(HIDDEN_CNT+1);
  localparam int unsigned CW = $clog2(HIDDEN_CNT);
  localparam int unsigned PW = $clog2(CLASS_CNT);
  localparam logic [FEAT_BITS-1:0] XMAX = '1;

  typedef enum logic [1:0] {
    PH_HIDDEN,
    PH_OUTPUT,
    PH_DONE
  } phase_t;

  phase_t                r_phase;
  logic [CW-1:0]         r_cnt;
  logic [HIDDEN_CNT-1:0] r_hidden;
  logic [SW-1:0]         r_best_score;
  logic [PW-1:0]         r_best_idx;
  logic [PW-1:0]         r_prediction;

  logic [FEAT_CNT-1:0]   w_w1;
  logic [S1-1:0]         w_t1;
  logic [HIDDEN_CNT-1:0] w_w2;
  logic [S1-1:0]         w_sum;
  logic                  w_hbit;
  logic [SW-1:0]         w_score;
  logic                  w_better;
  logic [PW-1:0]         w_cls;

  // Row select of the constant weight/threshold tables by the shared counter
  always_comb begin
    w_w1 = '0;
    w_t1 = '0;
    w_w2 = '0;
    for (int k = 0; k < HIDDEN_CNT; k++) begin
      if (r_cnt == CW'(k)) begin
        w_w1 = W1[k*FEAT_CNT +: FEAT_CNT];
        w_t1 = T1[k*S1 +: S1];
      end
    end
    for (int c = 0; c < CLASS_CNT; c++) begin
      if (r_cnt == CW'(c)) begin
        w_w2 = W2[c*HIDDEN_CNT +: HIDDEN_CNT];
      end
    end
  end

  // Hidden neuron: a zero weight bit uses the complemented feature value
  always_comb begin
    w_sum = '0;
    for (int j = 0; j < FEAT_CNT; j++) begin
      w_sum = w_sum + S1'(w_w1[j] ? features[j*FEAT_BITS +: FEAT_BITS]
                                  : XMAX - features[j*FEAT_BITS +: FEAT_BITS]);
    end
    w_hbit = (w_sum >= w_t1);
  end

  // Class score is the XNOR popcount; strict compare keeps the lowest index on ties
  always_comb begin
    w_score = '0;
    for (int k = 0; k < HIDDEN_CNT; k++) begin
      w_score = w_score + SW'(r_hidden[k] == w_w2[k]);
    end
    w_cls    = PW'(r_cnt);
    w_better = (r_cnt == '0) || (w_score > r_best_score);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_phase      <= PH_HIDDEN;
      r_cnt        <= '0;
      r_hidden     <= '0;
      r_best_score <= '0;
      r_best_idx   <= '0;
      r_prediction <= '0;
    end else begin
      case (r_phase)
        PH_HIDDEN: begin
          r_hidden <= r_hidden | (HIDDEN_CNT'(w_hbit) << r_cnt);
          if (r_cnt == CW'(HIDDEN_CNT-1)) begin
            r_cnt   <= '0;
            r_phase <= PH_OUTPUT;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        PH_OUTPUT: begin
          if (w_better) begin
            r_best_score <= w_score;
            r_best_idx   <= w_cls;
          end
          if (r_cnt == CW'(CLASS_CNT-1)) begin
            r_prediction <= w_better ? w_cls : r_best_idx;
            r_phase      <= PH_DONE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: begin
          r_phase <= r_phase;
        end
      endcase
    end
  end

  assign prediction = r_prediction;

endmodule

// File: tb/tb_har_bnn1_rospine_classifier.sv
// Bench for har_bnn1_rospine_classifier: directed and random feature words against an
// arithmetic reference model, on three weight configurations sharing one stimulus.
module tb_har_bnn1_rospine_classifier;

  localparam logic [479:0] W1_DEF = '1;
  localparam logic [319:0] T1_DEF = {40{8'd90}};
  localparam logic [239:0] W2_DEF = '0;
  localparam logic [239:0] W2_O   = {80'h0, 40'hFF_FFFF_FFFF, 120'h0};
  localparam logic [479:0] W1_M   = {20{24'hC3A596}};
  localparam logic [319:0] T1_M   = {5{8'd140, 8'd120, 8'd110, 8'd100, 8'd90, 8'd75, 8'd60, 8'd40}};
  localparam logic [239:0] W2_M   = {40'hF0F0F0F0F0, 40'h0123456789, 40'hAAAAAAAAAA,
                                     40'h5555555555, 40'hFFFFF00000, 40'h00000FFFFF};

  logic        clk;
  logic        rst;
  logic [47:0] features;
  logic [2:0]  pred_o;
  logic [2:0]  pred_d;
  logic [2:0]  pred_m;
  int          n_tests;
  int          n_fail;

  har_bnn1_rospine_classifier #(.W2(W2_O)) dut (
    .clk(clk), .rst(rst), .features(features), .prediction(pred_o));

  har_bnn1_rospine_classifier dut_def (
    .clk(clk), .rst(rst), .features(features), .prediction(pred_d));

  har_bnn1_rospine_classifier #(.W1(W1_M), .T1(T1_M), .W2(W2_M)) dut_mix (
    .clk(clk), .rst(rst), .features(features), .prediction(pred_m));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: hidden bits from weighted feature sums, then XNOR-count argmax
  function automatic logic [2:0] model(input logic [47:0] f, input logic [479:0] w1,
                                       input logic [319:0] t1, input logic [239:0] w2);
    logic [39:0] h;
    int sum, x, score, best, bi;
    best = 0;
    bi   = 0;
    for (int k = 0; k < 40; k++) begin
      sum = 0;
      for (int j = 0; j < 12; j++) begin
        x = int'(f[j*4 +: 4]);
        sum += w1[k*12 + j] ? x : 15 - x;
      end
      h[k] = (sum >= int'(t1[k*8 +: 8]));
    end
    for (int c = 0; c < 6; c++) begin
      score = 0;
      for (int k = 0; k < 40; k++) if (h[k] == w2[c*40 + k]) score++;
      if (c == 0 || score > best) begin
        best = score;
        bi   = c;
      end
    end
    return 3'(bi);
  endfunction

  task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reset, release on a falling edge, then sample just before and after the 46th edge
  task automatic run_case(input logic [47:0] f, input string tag, input logic [2:0] exp_o);
    logic [2:0] ed, em;
    ed = model(f, W1_DEF, T1_DEF, W2_DEF);
    em = model(f, W1_M, T1_M, W2_M);
    features = f;
    rst = 1'b0;
    @(negedge clk);
    check({tag, "_rst_o"}, pred_o, 3'd0);
    check({tag, "_rst_m"}, pred_m, 3'd0);
    rst = 1'b1;
    repeat (45) @(posedge clk);
    @(negedge clk);
    check({tag, "_e45_o"}, pred_o, 3'd0);
    check({tag, "_e45_m"}, pred_m, 3'd0);
    @(posedge clk);
    @(negedge clk);
    check({tag, "_e46_o"}, pred_o, exp_o);
    check({tag, "_e46_d"}, pred_d, ed);
    check({tag, "_e46_m"}, pred_m, em);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check({tag, "_e49_o"}, pred_o, exp_o);
    check({tag, "_e49_m"}, pred_m, em);
  endtask

  initial begin
    logic [47:0] f;
    logic [2:0]  em;
    n_tests  = 0;
    n_fail   = 0;
    rst      = 1'b0;
    features = '0;
    #1;
    check("por_o", pred_o, 3'd0);
    check("por_d", pred_d, 3'd0);
    check("por_m", pred_m, 3'd0);

    run_case(48'h0000_0000_0000, "all0", 3'd0);
    run_case(48'h0000_00FF_FFFF, "sum90", 3'd3);
    run_case(48'h0000_00EF_FFFF, "sum89", 3'd0);
    run_case(48'hFFFF_FFFF_FFFF, "all15", 3'd3);

    // Result must ignore feature changes once done
    em = model(48'hFFFF_FFFF_FFFF, W1_M, T1_M, W2_M);
    features = '0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("hold_o", pred_o, 3'd3);
    check("hold_m", pred_m, em);

    // Asynchronous reset clears a finished result without a clock edge
    #2 rst = 1'b0;
    #1;
    check("async_done_o", pred_o, 3'd0);
    check("async_done_m", pred_m, 3'd0);

    // Abort mid-computation, then full latency again from the new release
    features = 48'hFFFF_FFFF_FFFF;
    @(negedge clk);
    rst = 1'b1;
    repeat (20) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("abort_o", pred_o, 3'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (45) @(posedge clk);
    @(negedge clk);
    check("rel_e45_o", pred_o, 3'd0);
    @(posedge clk);
    @(negedge clk);
    check("rel_e46_o", pred_o, 3'd3);
    check("rel_e46_m", pred_m, em);

    for (int i = 0; i < 20; i++) begin
      f = {16'($urandom), 32'($urandom)};
      run_case(f, $sformatf("rnd%0d", i), model(f, W1_DEF, T1_DEF, W2_O));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/har_bnn1_rospine_classifier.md
Name: har_bnn1_rospine_classifier

Overview:
- Sequential binarized-neural-network classifier for the HAR activity dataset: 12 features of 4 bits, 40 binary hidden neurons, 6 output classes.
- Evaluates one hidden neuron per clock, then one class score per clock, and tracks the argmax as it goes.
- Presents the winning class index on `prediction`.
- Sits as a standalone inference core fed by a static feature word; sequential evaluation keeps area small.

Parameters:
- FEAT_CNT, 12: number of input features.
- HIDDEN_CNT, 40: number of hidden neurons.
- FEAT_BITS, 4: bits per feature, unsigned.
- CLASS_CNT, 6: number of output classes.
- W1, all ones (HIDDEN_CNT*FEAT_CNT bits): hidden weights. Neuron k uses bits [k*FEAT_CNT +: FEAT_CNT]; bit j pairs with feature j.
- T1, every 8-bit field = 90 (HIDDEN_CNT*S1 bits): hidden thresholds. Neuron k uses [k*S1 +: S1], where S1 = clog2(FEAT_CNT*(2^FEAT_BITS-1)+1) = 8.
- W2, all zeros (CLASS_CNT*HIDDEN_CNT bits): output weights. Class c uses [c*HIDDEN_CNT +: HIDDEN_CNT]; bit k pairs with hidden k.

Ports:
- clk, input, 1: rising-edge clock.
- rst, input, 1: reset, asynchronous, active-low.
- features, input, FEAT_CNT*FEAT_BITS: feature j is features[j*FEAT_BITS +: FEAT_BITS]. Must stay stable from reset release until the result is valid.
- prediction, output, clog2(CLASS_CNT) = 3: index of the winning class.

Behaviour:
- Reset (rst=0, async):
  - phase=HIDDEN, counter=0, hidden vector=0, best_score=0, best_idx=0, prediction=0.
  - Assertion at any time, including mid-computation, aborts the computation immediately and forces these values.
- HIDDEN phase, cycles 0..HIDDEN_CNT-1 after release, one neuron k=counter per rising edge:
  - sum_k = Σ_j (W1[k][j] ? x_j : (2^FEAT_BITS-1 - x_j)), computed at S1 bits, no overflow possible.
  - hidden[k] <= (sum_k >= T1[k]), unsigned compare; equality counts as 1.
  - After k = HIDDEN_CNT-1: counter <= 0, phase <= OUTPUT.
- OUTPUT phase, CLASS_CNT cycles, one class c=counter per edge:
  - score_c = popcount(~(hidden ^ W2[c])), width clog2(HIDDEN_CNT+1) = 6.
  - Update best_score/best_idx to (score_c, c) if c==0 or score_c > best_score. Strict compare, so ties keep the lowest index.
  - The score for the last class is compared combinationally. On that edge, prediction <= final argmax and phase <= DONE.
- DONE phase: all state and prediction hold until the next reset. features changes are ignored.
- prediction reads 0 from reset until the DONE edge.
- Latency: valid after exactly HIDDEN_CNT+CLASS_CNT = 46 rising edges following reset deassertion. A sample taken at 47 edges or later is guaranteed valid.
- The counter is 6 bits and never wraps outside its phase range.
- Weights and thresholds are constants; all datapath logic is combinational per cycle with registered state.

Test Plan:
- Overrides: W2 class 3 = all ones, other classes all zeros; defaults otherwise. All features 15 → each sum = 180 ≥ 90 → hidden all 1 → class 3 score 40, others 0 → prediction=3 after 46 edges.
- Same overrides, all features 0 → hidden all 0 → classes 0,1,2,4,5 score 40, class 3 score 0 → tie resolves to lowest → prediction=0.
- Threshold boundary, same overrides:
  - features 0..5 = 15, rest 0 → sum = 90 → hidden 1 → prediction=3.
  - feature 5 changed to 14 → sum = 89 → prediction=0.
- Same overrides, all features 15: check prediction=0 at edge 45 and prediction=3 at edge 46 and beyond. Then change features to 0 and confirm prediction stays 3.
- Reset mid-operation: all features 15, pull rst low asynchronously after 20 edges → prediction=0 immediately. Release → prediction=3 exactly 46 edges later.
- Defaults only (W2 all zeros), any features → all scores tie → prediction=0.
